// File: rtl/load_store_unit_if.sv
// Load/store unit bus interface.
// Bundles the core-side request/response signals and the memory-side port.
//   slave  : seen by load_store_unit (takes requests, drives memory port)
//   master : seen by the core/memory environment
// Core side : start, is_store, funct3, base, offset, wdata -> busy, done,
//             rdata, misaligned, timeout
// Mem side  : mem_addr, mem_rstrb, mem_wmask, mem_wdata -> mem_rdata, mem_ready
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       base;
  logic [31:0]       offset;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic              misaligned;
  logic              timeout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  start, is_store, funct3, base, offset, wdata, mem_rdata, mem_ready,
    output busy, done, rdata, misaligned, timeout,
           mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );

  modport master (
    output start, is_store, funct3, base, offset, wdata, mem_rdata, mem_ready,
    input  busy, done, rdata, misaligned, timeout,
           mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store engine.
// Accepts one access per start pulse (IDLE only), computes ea = base + offset,
// drives a word-aligned memory port for one cycle (read strobe or byte write
// mask), waits for mem_ready, and returns sign/zero-extended load data.
// Misaligned accesses either fault (ALIGN_TRAP=1) or are forced aligned.
// A WAIT phase longer than MAX_WAIT cycles completes with timeout (0 = never).
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   bus         : load_store_unit_if.slave (core request/response + memory)
module load_store_unit #(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          ALIGN_TRAP = 1'b1,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic             clk,
  input  logic             resetn,
  load_store_unit_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT =
    (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FAULT} state_t;

  state_t state, state_next;

  logic [31:0]       ea;
  logic              mis_req;
  logic              trap_req;
  logic [1:0]        ea_lo_fix;
  logic [31:0]       wdata_rep;
  logic              start_ok;
  logic              ready_now;
  logic              tmo_now;

  logic [1:0]        ea_lo_q;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              done_q;
  logic              mis_q;
  logic              tmo_q;
  logic [31:0]       rdata_q;

  logic [15:0]       ld_half;
  logic [7:0]        ld_byte;
  logic [31:0]       ld_fmt;
  logic [3:0]        st_mask;

  assign ea = bus.base + bus.offset;

  // Request decode; without trapping, the offending low bits are cleared so
  // the access degrades to the naturally aligned one containing it.
  always_comb begin
    mis_req   = (bus.funct3[1] && (ea[1:0] != 2'b00)) ||
                ((bus.funct3[1:0] == 2'b01) && ea[0]);
    trap_req  = ALIGN_TRAP && mis_req;
    ea_lo_fix = ea[1:0];
    if (!ALIGN_TRAP) begin
      if (bus.funct3[1])      ea_lo_fix = 2'b00;
      else if (bus.funct3[0]) ea_lo_fix[0] = 1'b0;
    end
    case (bus.funct3[1:0])
      2'b00:   wdata_rep = {4{bus.wdata[7:0]}};
      2'b01:   wdata_rep = {2{bus.wdata[15:0]}};
      default: wdata_rep = bus.wdata;
    endcase
  end

  assign start_ok  = (state == IDLE) && bus.start;
  // Responses outside ISSUE/WAIT are stale and dropped here.
  assign ready_now = bus.mem_ready && ((state == ISSUE) || (state == WAIT));
  // A response on the limit cycle takes priority over the timeout.
  assign tmo_now   = (MAX_WAIT != 0) && (state == WAIT) && !bus.mem_ready &&
                     (wait_cnt == WAIT_LIMIT);

  // Load formatting and store byte-lane selection from the latched access.
  always_comb begin
    ld_half = ea_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_byte = ea_lo_q[0] ? ld_half[15:8] : ld_half[7:0];
    case (funct3_q[1:0])
      2'b00: begin
        ld_fmt  = {{24{!funct3_q[2] && ld_byte[7]}}, ld_byte};
        st_mask = 4'b0001 << ea_lo_q;
      end
      2'b01: begin
        ld_fmt  = {{16{!funct3_q[2] && ld_half[15]}}, ld_half};
        st_mask = 4'b0011 << {ea_lo_q[1], 1'b0};
      end
      default: begin
        ld_fmt  = bus.mem_rdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = trap_req ? FAULT : ISSUE;
      ISSUE: state_next = bus.mem_ready ? IDLE : WAIT;
      WAIT:  if (bus.mem_ready || tmo_now) state_next = IDLE;
      FAULT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.mem_rstrb = (state == ISSUE) && !store_q;
    bus.mem_wmask = ((state == ISSUE) && store_q) ? st_mask : '0;
  end

  // Access registers and registered completion outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ea_lo_q  <= '0;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q <= ready_now || tmo_now || (state == FAULT);
      mis_q  <= (state == FAULT);
      tmo_q  <= tmo_now;
      if (ready_now && !store_q) rdata_q <= ld_fmt;
      if (start_ok) begin
        store_q  <= bus.is_store;
        funct3_q <= bus.funct3;
        ea_lo_q  <= ea_lo_fix;
        wait_cnt <= '0;
        if (!trap_req) begin
          addr_q  <= {ea[ADDR_W-1:2], 2'b00};
          wdata_q <= wdata_rep;
        end
      end else if ((state == WAIT) && !bus.mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
  assign bus.timeout    = tmo_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: dut_a (ALIGN_TRAP=1, MAX_WAIT=4) and
// dut_b (ALIGN_TRAP=0) each with a simple variable-latency memory responder.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus_a ();
  load_store_unit_if #(.ADDR_W(32)) bus_b ();

  load_store_unit #(.ADDR_W(32), .ALIGN_TRAP(1'b1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a.slave));
  load_store_unit #(.ADDR_W(32), .ALIGN_TRAP(1'b0), .MAX_WAIT(255)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b.slave));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        mis;
    logic        tmo;
    int          lat;
    int          strobes;
    int          sbase;
    logic        st;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_done = 0;
  int   next_id = 0;

  always @(posedge clk) cyc++;

  // Shared word memory, byte addresses 0..1023
  logic [31:0] mem [0:255];
  bit          mem_init = 1'b0;
  int          ready_delay = 1;

  // Responder A: answers ready_delay cycles after the strobe cycle.
  int          pend_a = 0;
  int          cnt_a = 0;
  logic [31:0] addr_a;
  int          strobe_total = 0;
  logic [3:0]  seen_mask;
  logic [31:0] seen_wdata;
  logic [31:0] seen_addr;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[100] = 32'h04030201;
      mem[102] = 32'h04030605;
      mem[103] = 32'hFF0F0E0D;
      mem_init = 1'b1;
    end
    bus_a.mem_ready = 1'b0;
    if (pend_a != 0) begin
      if (cnt_a == 0) begin
        bus_a.mem_ready = 1'b1;
        bus_a.mem_rdata = mem[addr_a[9:2]];
        pend_a = 0;
      end else begin
        cnt_a--;
      end
    end
    if (bus_a.mem_rstrb || (bus_a.mem_wmask != 4'b0000)) begin
      strobe_total++;
      seen_mask  = bus_a.mem_wmask;
      seen_wdata = bus_a.mem_wdata;
      seen_addr  = bus_a.mem_addr;
      for (int b = 0; b < 4; b++)
        if (bus_a.mem_wmask[b]) mem[bus_a.mem_addr[9:2]][8*b +: 8] = bus_a.mem_wdata[8*b +: 8];
      pend_a = 1;
      cnt_a  = ready_delay - 1;
      addr_a = bus_a.mem_addr;
    end
  end

  // Responder B: read-only, fixed one-cycle latency.
  int          pend_b = 0;
  logic [31:0] addr_b;
  logic [31:0] seen_addr_b;

  always @(negedge clk) begin
    bus_b.mem_ready = 1'b0;
    if (pend_b != 0) begin
      bus_b.mem_ready = 1'b1;
      bus_b.mem_rdata = mem[addr_b[9:2]];
      pend_b = 0;
    end
    if (bus_b.mem_rstrb) begin
      pend_b      = 1;
      addr_b      = bus_b.mem_addr;
      seen_addr_b = bus_b.mem_addr;
    end
  end

  // Completion monitor for dut_a: every done pops one expectation.
  always @(negedge clk) begin
    if (bus_a.done) begin
      n_done++;
      if (sb.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq($sformatf("rdata#%0d", mon_e.id), bus_a.rdata, mon_e.rdata);
        check_eq($sformatf("misaligned#%0d", mon_e.id), 32'(bus_a.misaligned), 32'(mon_e.mis));
        check_eq($sformatf("timeout#%0d", mon_e.id), 32'(bus_a.timeout), 32'(mon_e.tmo));
        check_eq($sformatf("busy_at_done#%0d", mon_e.id), 32'(bus_a.busy), 32'd0);
        check_eq($sformatf("strobes#%0d", mon_e.id), 32'(strobe_total - mon_e.sbase), 32'(mon_e.strobes));
        if (mon_e.lat > 0)
          check_eq($sformatf("latency#%0d", mon_e.id), 32'(cyc - start_cyc), 32'(mon_e.lat));
        if (mon_e.strobes > 0) begin
          check_eq($sformatf("mem_addr#%0d", mon_e.id), seen_addr, mon_e.addr);
          check_eq($sformatf("wmask#%0d", mon_e.id), 32'(seen_mask), 32'(mon_e.mask));
          if (mon_e.st)
            check_eq($sformatf("mem_wdata#%0d", mon_e.id), seen_wdata, mon_e.wdata);
        end
      end
    end
  end

  task automatic drive_a(input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd);
    @(negedge clk);
    bus_a.start    = 1'b1;
    bus_a.is_store = st;
    bus_a.funct3   = f3;
    bus_a.base     = b;
    bus_a.offset   = o;
    bus_a.wdata    = wd;
    start_cyc      = cyc;
    @(negedge clk);
    bus_a.start    = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_done >= target) return;
    end
    check_eq("done_wait_expired", 32'd0, 32'd1);
  endtask

  // Push expectation, issue, wait for completion.
  task automatic run_a(input logic st, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                       input logic [31:0] e_rdata, input logic e_mis, input logic e_tmo,
                       input int e_lat, input int e_strobes,
                       input logic [3:0] e_mask, input logic [31:0] e_wdata,
                       input logic [31:0] e_addr);
    exp_t e;
    int   target;
    e.id      = next_id;
    e.rdata   = e_rdata;
    e.mis     = e_mis;
    e.tmo     = e_tmo;
    e.lat     = e_lat;
    e.strobes = e_strobes;
    e.sbase   = strobe_total;
    e.st      = st;
    e.mask    = e_mask;
    e.wdata   = e_wdata;
    e.addr    = e_addr;
    next_id++;
    sb.push_back(e);
    target = n_done + 1;
    drive_a(st, f3, b, o, wd);
    wait_done(target, 20);
  endtask

  task automatic check_idle_a(input string pfx);
    check_eq({pfx, "_busy"},       32'(bus_a.busy),       32'd0);
    check_eq({pfx, "_done"},       32'(bus_a.done),       32'd0);
    check_eq({pfx, "_misaligned"}, 32'(bus_a.misaligned), 32'd0);
    check_eq({pfx, "_timeout"},    32'(bus_a.timeout),    32'd0);
    check_eq({pfx, "_rdata"},      bus_a.rdata,           32'd0);
    check_eq({pfx, "_mem_rstrb"},  32'(bus_a.mem_rstrb),  32'd0);
    check_eq({pfx, "_mem_wmask"},  32'(bus_a.mem_wmask),  32'd0);
    check_eq({pfx, "_mem_addr"},   bus_a.mem_addr,        32'd0);
    check_eq({pfx, "_mem_wdata"},  bus_a.mem_wdata,       32'd0);
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  initial begin
    int tgt;
    int sbase;
    int got;
    bus_a.start = 1'b0; bus_a.is_store = 1'b0; bus_a.funct3 = '0;
    bus_a.base = '0; bus_a.offset = '0; bus_a.wdata = '0;
    bus_b.start = 1'b0; bus_b.is_store = 1'b0; bus_b.funct3 = '0;
    bus_b.base = '0; bus_b.offset = '0; bus_b.wdata = '0;

    repeat (3) @(negedge clk);
    check_idle_a("reset");
    resetn = 1'b1;

    // Loads with one-cycle memory latency
    run_a(1'b0, F_B,  32'd0,   32'd415, '0, 32'hFFFFFFFF, 0, 0, 3, 1, 4'b0000, '0, 32'd412);
    run_a(1'b0, F_BU, 32'd0,   32'd415, '0, 32'h000000FF, 0, 0, 3, 1, 4'b0000, '0, 32'd412);
    run_a(1'b0, F_B,  32'd0,   32'd401, '0, 32'h00000002, 0, 0, 3, 1, 4'b0000, '0, 32'd400);
    run_a(1'b0, F_H,  32'd410, 32'd0,   '0, 32'h00000403, 0, 0, 3, 1, 4'b0000, '0, 32'd408);
    run_a(1'b0, F_HU, 32'd414, 32'd0,   '0, 32'h0000FF0F, 0, 0, 3, 1, 4'b0000, '0, 32'd412);
    run_a(1'b0, F_W,  32'd500, 32'hFFFFFF9C, '0, 32'h04030201, 0, 0, 3, 1, 4'b0000, '0, 32'd400);

    // Stores; rdata keeps the last load result
    run_a(1'b1, F_B, 32'd402, 32'd0, 32'h123456AB, 32'h04030201, 0, 0, 3, 1, 4'b0100, 32'hABABABAB, 32'd400);
    run_a(1'b1, F_H, 32'd400, 32'd6, 32'h123456AB, 32'h04030201, 0, 0, 3, 1, 4'b1100, 32'h56AB56AB, 32'd404);
    run_a(1'b1, F_W, 32'd420, 32'd0, 32'hDEADBEEF, 32'h04030201, 0, 0, 3, 1, 4'b1111, 32'hDEADBEEF, 32'd420);
    run_a(1'b0, F_W, 32'd400, 32'd0, '0, 32'h04AB0201, 0, 0, 3, 1, 4'b0000, '0, 32'd400);
    run_a(1'b0, F_W, 32'd404, 32'd0, '0, 32'h56AB0000, 0, 0, 3, 1, 4'b0000, '0, 32'd404);

    // Alignment faults: no memory activity, rdata held
    run_a(1'b0, F_W, 32'd400, 32'd2, '0, 32'h56AB0000, 1, 0, 2, 0, 4'b0000, '0, '0);
    run_a(1'b1, F_H, 32'd405, 32'd0, 32'hCAFEF00D, 32'h56AB0000, 1, 0, 2, 0, 4'b0000, '0, '0);

    // Timeout after 4 silent WAIT cycles; the late response must be ignored
    ready_delay = 8;
    run_a(1'b0, F_W, 32'd400, 32'd0, '0, 32'h56AB0000, 0, 1, 6, 1, 4'b0000, '0, 32'd400);
    repeat (6) @(negedge clk);
    ready_delay = 1;
    run_a(1'b0, F_W, 32'd412, 32'd0, '0, 32'hFF0F0E0D, 0, 0, 3, 1, 4'b0000, '0, 32'd412);

    // Response on the limit cycle completes normally
    ready_delay = 4;
    run_a(1'b0, F_W, 32'd420, 32'd0, '0, 32'hDEADBEEF, 0, 0, 6, 1, 4'b0000, '0, 32'd420);

    // start while busy is ignored
    ready_delay = 3;
    sb.push_back('{next_id, 32'h04AB0201, 1'b0, 1'b0, 5, 1, strobe_total, 1'b0, 4'b0000, 32'h0, 32'd400});
    next_id++;
    tgt = n_done + 1;
    sbase = strobe_total;
    drive_a(1'b0, F_W, 32'd400, 32'd0, '0);
    @(negedge clk);
    check_eq("busy_mid_access", 32'(bus_a.busy), 32'd1);
    bus_a.start = 1'b1; bus_a.base = 32'd412; bus_a.funct3 = F_B;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_done(tgt, 20);
    repeat (6) @(negedge clk);
    check_eq("ignored_start_strobes", 32'(strobe_total - sbase), 32'd1);

    // Reset while in WAIT abandons the access; its response arrives later
    ready_delay = 4;
    drive_a(1'b0, F_W, 32'd420, 32'd0, '0);
    @(negedge clk);
    check_eq("busy_before_reset", 32'(bus_a.busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_idle_a("midreset");
    repeat (6) @(negedge clk);
    ready_delay = 1;
    run_a(1'b0, F_W, 32'd412, 32'd0, '0, 32'hFF0F0E0D, 0, 0, 3, 1, 4'b0000, '0, 32'd412);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    // ALIGN_TRAP=0 instance: misaligned accesses are forced aligned
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.funct3 = F_W; bus_b.base = 32'd400; bus_b.offset = 32'd2;
    @(negedge clk);
    bus_b.start = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus_b.done) begin got = 1; break; end
    end
    check_eq("b_lw_done", 32'(got), 32'd1);
    check_eq("b_lw_rdata", bus_b.rdata, 32'h04AB0201);
    check_eq("b_lw_misaligned", 32'(bus_b.misaligned), 32'd0);
    check_eq("b_lw_addr", seen_addr_b, 32'd400);

    @(negedge clk);
    bus_b.start = 1'b1; bus_b.funct3 = F_H; bus_b.base = 32'd403; bus_b.offset = 32'd0;
    @(negedge clk);
    bus_b.start = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus_b.done) begin got = 1; break; end
    end
    check_eq("b_lh_done", 32'(got), 32'd1);
    check_eq("b_lh_rdata", bus_b.rdata, 32'h000004AB);
    check_eq("b_lh_misaligned", 32'(bus_b.misaligned), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

endmodule
